load_block: RTL and testbench



---
 rtl/load_block.sv | 154 +++++++++++++++
 tb/tb_load_block.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_block.sv
// Load unit between the memory stage and the data-memory port: fetches one or two
// aligned words over req/ack, then extracts and sign/zero-extends LB/LH/LW/LBU/LHU.
module load_block (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] data_out,
    output logic        done,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ0 = 2'd1,
        REQ1 = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] r_w0;
    logic [31:0] r_w1;
    logic        r_inv;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [31:0] r_data_out;
    logic        r_done;
    logic        r_busy;
    logic        r_err;
    logic        w_split;

    function automatic logic f_valid(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: f_valid = 1'b1;
            default:                             f_valid = 1'b0;
        endcase
    endfunction

    // Only called with a latched, valid funct3, so f3[1:0]==10 means LW.
    function automatic logic f_split(input logic [2:0] f3, input logic [1:0] off);
        f_split = ((f3[1:0] == 2'b01) && (off == 2'b11)) ||
                  ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [31:0] f_extract(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] w0,
                                              input logic [31:0] w1);
        logic [63:0]        v;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        v  = {w1, w0} >> {off, 3'b000};
        sb = v[7:0];
        sh = v[15:0];
        case (f3)
            F3_LB:   f_extract = 32'(sb);
            F3_LH:   f_extract = 32'(sh);
            F3_LBU:  f_extract = {24'd0, v[7:0]};
            F3_LHU:  f_extract = {16'd0, v[15:0]};
            default: f_extract = v[31:0];
        endcase
    endfunction

    assign w_split = f_split(r_funct3, r_off);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_funct3   <= 3'd0;
            r_off      <= 2'd0;
            r_w0       <= 32'd0;
            r_w1       <= 32'd0;
            r_inv      <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'd0;
            r_data_out <= 32'd0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_funct3 <= funct3;
                        r_off    <= addr[1:0];
                        r_w1     <= 32'd0;
                        r_busy   <= 1'b1;
                        if (f_valid(funct3)) begin
                            r_inv      <= 1'b0;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {addr[31:2], 2'b00};
                            r_state    <= REQ0;
                        end else begin
                            r_inv   <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                REQ0: begin
                    if (mem_ack) begin
                        r_w0 <= mem_rdata;
                        if (w_split) begin
                            // Word address wraps naturally at the top of the 32-bit space.
                            r_mem_addr <= r_mem_addr + 32'd4;
                            r_state    <= REQ1;
                        end else begin
                            r_mem_req <= 1'b0;
                            r_state   <= FIN;
                        end
                    end
                end
                REQ1: begin
                    if (mem_ack) begin
                        r_w1      <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= FIN;
                    end
                end
                FIN: begin
                    r_done     <= 1'b1;
                    r_err      <= r_inv;
                    r_data_out <= r_inv ? 32'd0 : f_extract(r_funct3, r_off, r_w0, r_w1);
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign data_out = r_data_out;
    assign done     = r_done;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_load_block.sv
// Directed bench for load_block: byte-level memory model, wait-state responder and
// a single negedge process comparing handshake, latency and results against the model.
`timescale 1ns/1ps
module tb_load_block;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic [31:0] data_out;
    logic        done;
    logic        busy;
    logic        err;

    load_block dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .addr      (addr),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .data_out  (data_out),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    bit          outstanding = 1'b0;
    bit          seen_done   = 1'b0;
    bit          exp_inv     = 1'b0;
    logic [31:0] exp_data    = 32'd0;
    int          exp_lat     = 0;
    int          exp_n       = 0;
    int          acc_n       = 0;
    int          t_start     = 0;
    int          wait_n      = 0;
    int          wcnt        = 0;
    logic [31:0] exp_addr0   = 32'd0;
    logic [31:0] exp_addr1   = 32'd0;
    bit          prev_wait   = 1'b0;
    logic [31:0] prev_addr   = 32'd0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %08h required %08h", name, act, req);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        case (wa)
            32'h0000_0100: return 32'h80FF7F01;
            32'h0000_0104: return 32'hDDCCBBAA;
            32'hFFFF_FFFC: return 32'h44332211;
            32'h0000_0000: return 32'h88776655;
            default:       return 32'hA5A5A5A5 ^ wa;
        endcase
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    // Reference: gather the addressed bytes one at a time and extend.
    task automatic model(input logic [2:0] f3, input logic [31:0] a,
                         output logic [31:0] val, output bit inv, output int nacc);
        int size;
        logic [31:0] last;
        inv  = 1'b0;
        val  = 32'd0;
        nacc = 0;
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default: begin inv = 1'b1; size = 0; end
        endcase
        if (!inv) begin
            for (int i = 0; i < size; i++)
                val = val | (32'(mem_byte(a + 32'(i))) << (8 * i));
            if (!f3[2] && size < 4 && val[8*size-1])
                val = val | (32'hFFFFFFFF << (8 * size));
            last = a + 32'(size - 1);
            nacc = (last[31:2] != a[31:2]) ? 2 : 1;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mem_ack   = 1'b0;
            wcnt      = 0;
            prev_wait = 1'b0;
        end else begin
            if (mem_req) begin
                chk(mem_addr[1:0] == 2'b00, "addr_aligned", mem_addr, {mem_addr[31:2], 2'b00});
                if (prev_wait) chk(mem_addr == prev_addr, "addr_stable", mem_addr, prev_addr);
            end
            if (outstanding && exp_inv) chk(mem_req == 1'b0, "inv_no_req", 32'(mem_req), 32'd0);
            if (outstanding && cyc == t_start) chk(busy == 1'b1, "busy_after_start", 32'(busy), 32'd1);

            if (mem_req && wcnt >= wait_n) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                if (outstanding) begin
                    if (acc_n < exp_n)
                        chk(mem_addr == (acc_n == 0 ? exp_addr0 : exp_addr1), "access_addr",
                            mem_addr, (acc_n == 0 ? exp_addr0 : exp_addr1));
                    else
                        chk(1'b0, "extra_access", mem_addr, 32'd0);
                    acc_n++;
                end
                wcnt      = 0;
                prev_wait = 1'b0;
            end else if (mem_req) begin
                mem_ack   = 1'b0;
                wcnt++;
                prev_wait = 1'b1;
                prev_addr = mem_addr;
            end else begin
                mem_ack   = 1'b0;
                wcnt      = 0;
                prev_wait = 1'b0;
            end

            if (done) begin
                if (outstanding) begin
                    chk(data_out == exp_data, "data_out", data_out, exp_data);
                    chk(err == exp_inv, "err", 32'(err), 32'(exp_inv));
                    chk(cyc - t_start == exp_lat, "latency", 32'(cyc - t_start), 32'(exp_lat));
                    chk(acc_n == exp_n, "access_count", 32'(acc_n), 32'(exp_n));
                    outstanding = 1'b0;
                    seen_done   = 1'b1;
                end else begin
                    chk(1'b0, "spurious_done", 32'(done), 32'd0);
                end
            end else if (!outstanding) begin
                chk(err == 1'b0, "idle_err", 32'(err), 32'd0);
            end
        end
    end

    task automatic begin_load(input logic [2:0] f3, input logic [31:0] a, input int waits,
                              input logic [31:0] lit);
        logic [31:0] m;
        bit          inv;
        int          n;
        model(f3, a, m, inv, n);
        chk(m == lit, "model_literal", m, lit);
        @(negedge clk);
        exp_data    = m;
        exp_inv     = inv;
        exp_n       = n;
        acc_n       = 0;
        exp_addr0   = {a[31:2], 2'b00};
        exp_addr1   = {a[31:2], 2'b00} + 32'd4;
        exp_lat     = inv ? 1 : n * (1 + waits) + 1;
        wait_n      = waits;
        t_start     = cyc + 1;
        seen_done   = 1'b0;
        outstanding = 1'b1;
        start       = 1'b1;
        funct3      = f3;
        addr        = a;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'b111;
        addr   = 32'h0000_0FFF;
    endtask

    task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input int waits,
                            input logic [31:0] lit, input bit poke_busy);
        begin_load(f3, a, waits, lit);
        if (poke_busy) begin
            repeat (2) @(posedge clk);
            #1;
            start  = 1'b1;
            funct3 = 3'b000;
            addr   = 32'h0000_0100;
            @(posedge clk);
            #1;
            start  = 1'b0;
        end
        for (int i = 0; i < 40 && !seen_done; i++) @(posedge clk);
        if (!seen_done) begin
            chk(1'b0, "done_timeout", 32'(cyc), 32'(t_start + exp_lat));
            outstanding = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        chk({mem_req, busy, done, err} == 4'd0, "reset_ctl", {28'd0, mem_req, busy, done, err}, 32'd0);
        chk(data_out == 32'd0, "reset_data", data_out, 32'd0);
        chk(mem_addr == 32'd0, "reset_addr", mem_addr, 32'd0);
        rst = 1'b0;

        run_load(3'b000, 32'h0000_0101, 0, 32'h0000007F, 1'b0);
        run_load(3'b000, 32'h0000_0102, 0, 32'hFFFFFFFF, 1'b0);
        run_load(3'b100, 32'h0000_0102, 0, 32'h000000FF, 1'b0);
        run_load(3'b001, 32'h0000_0102, 0, 32'hFFFF80FF, 1'b0);
        run_load(3'b101, 32'h0000_0102, 0, 32'h000080FF, 1'b0);
        run_load(3'b010, 32'h0000_0100, 0, 32'h80FF7F01, 1'b0);
        run_load(3'b010, 32'h0000_0103, 0, 32'hCCBBAA80, 1'b0);
        run_load(3'b001, 32'h0000_0103, 0, 32'hFFFFAA80, 1'b0);
        run_load(3'b101, 32'h0000_0103, 0, 32'h0000AA80, 1'b0);
        run_load(3'b010, 32'h0000_0101, 3, 32'hAA80FF7F, 1'b1);
        run_load(3'b011, 32'h0000_0100, 0, 32'h00000000, 1'b0);
        run_load(3'b110, 32'h0000_0101, 0, 32'h00000000, 1'b0);
        run_load(3'b111, 32'h0000_0102, 0, 32'h00000000, 1'b0);
        run_load(3'b010, 32'hFFFF_FFFE, 0, 32'h66554433, 1'b0);

        begin_load(3'b010, 32'h0000_0103, 3, 32'hCCBBAA80);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h0000_0104) begin
                found = 1'b1;
                break;
            end
        end
        chk(found, "reach_req1", 32'(found), 32'd1);
        #2;
        outstanding = 1'b0;
        rst = 1'b1;
        #1;
        chk(mem_req == 1'b0, "rst_mem_req", 32'(mem_req), 32'd0);
        chk(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);
        chk(done == 1'b0, "rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_load(3'b000, 32'h0000_0100, 0, 32'h00000001, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
